// File: rtl/uart_pkg.sv
// Shared UART constants: character width and default transmit FIFO depth.
// Imported by the transmit FIFO, its interface and its storage array.
package uart_pkg;

   localparam int unsigned UART_DATA_W             = 8;
   localparam int unsigned UART_TX_FIFO_DEPTH_LOG2 = 4;
   localparam int unsigned UART_TX_FIFO_DEPTH      = 2 ** UART_TX_FIFO_DEPTH_LOG2;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo_if.sv
// Producer/consumer handshake of the UART transmit FIFO.
// Optional level/almost_full signals exist only when UART_TX_FIFO_LEVEL_EN is defined.
interface uart_tx_fifo_if
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH      = UART_DATA_W,
   parameter int unsigned DEPTH_LOG2 = UART_TX_FIFO_DEPTH_LOG2
) ();

   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             full;
   logic             read;
   logic             empty;
   logic [WIDTH-1:0] data;
   logic             overflow;
   logic             underflow;
`ifdef UART_TX_FIFO_LEVEL_EN
   logic [DEPTH_LOG2:0] level;
   logic                almost_full;

   modport master (
      output wr_en, wr_data, read,
      input  full, empty, data, overflow, underflow, level, almost_full
   );

   modport slave (
      input  wr_en, wr_data, read,
      output full, empty, data, overflow, underflow, level, almost_full
   );
`else
   modport master (
      output wr_en, wr_data, read,
      input  full, empty, data, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, read,
      output full, empty, data, overflow, underflow
   );
`endif

endinterface : uart_tx_fifo_if

// File: rtl/uart_tx_fifo_mem.sv
// Storage array for the UART transmit FIFO: one synchronous write port,
// one asynchronous read port, no reset.
module uart_tx_fifo_mem
   import uart_pkg::*;
#(
   parameter int unsigned ADDR_W = UART_TX_FIFO_DEPTH_LOG2,
   parameter int unsigned WIDTH  = UART_DATA_W
) (
   input  logic              clk,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o
);

   logic [WIDTH-1:0] mem_q [2**ADDR_W];

   // NOTE: the array is deliberately not reset; stale contents are never
   // visible because the pointers decide which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule : uart_tx_fifo_mem

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: pointer/flag control and registered pop data.
// Define UART_TX_FIFO_LEVEL_EN to add the level and almost_full outputs.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = UART_TX_FIFO_DEPTH_LOG2,
   parameter int unsigned WIDTH      = UART_DATA_W
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_fifo_if.slave fifo_if
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

   typedef logic [DEPTH_LOG2:0]   ptr_t;
   typedef logic [DEPTH_LOG2-1:0] idx_t;

   localparam ptr_t PTR_ONE = ptr_t'(1);

   ptr_t             wr_ptr_q, wr_ptr_d;
   ptr_t             rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             full;
   logic             empty;
   logic             rd_ok;
   logic             wr_ok;
   logic [WIDTH-1:0] mem_rd_data;

   // Flags come only from registered pointers, so no input reaches them combinationally.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                  (wr_ptr_q[DEPTH_LOG2]     != rd_ptr_q[DEPTH_LOG2]);

   // A pop frees the slot being written, so a write while full is legal if a read is accepted too.
   assign rd_ok = fifo_if.read  && !empty;
   assign wr_ok = fifo_if.wr_en && (!full || rd_ok);

   always_comb begin
      // NOTE: every next-state signal gets a default first so no latch is inferred.
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      data_d      = data_q;
      overflow_d  = fifo_if.wr_en && !wr_ok;
      underflow_d = fifo_if.read  && empty;

      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         data_d   = mem_rd_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         data_q      <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         data_q      <= data_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   uart_tx_fifo_mem #(
      .ADDR_W (DEPTH_LOG2),
      .WIDTH  (WIDTH)
   ) u_mem (
      .clk       (clk),
      .wr_en_i   (wr_ok),
      .wr_addr_i (idx_t'(wr_ptr_q[DEPTH_LOG2-1:0])),
      .wr_data_i (fifo_if.wr_data),
      .rd_addr_i (idx_t'(rd_ptr_q[DEPTH_LOG2-1:0])),
      .rd_data_o (mem_rd_data)
   );

   assign fifo_if.full      = full;
   assign fifo_if.empty     = empty;
   assign fifo_if.data      = data_q;
   assign fifo_if.overflow  = overflow_q;
   assign fifo_if.underflow = underflow_q;

`ifdef UART_TX_FIFO_LEVEL_EN
   ptr_t level;

   assign level               = wr_ptr_q - rd_ptr_q;
   assign fifo_if.level       = level;
   assign fifo_if.almost_full = (level >= ptr_t'(DEPTH - 2));
`endif

endmodule : uart_tx_fifo

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DEPTH_LOG2, default 4, SHALL set the log2 of the number of entries (DEPTH = 2**DEPTH_LOG2).
REQ-003 Parameter WIDTH, default 8, SHALL set the entry width in bits.
REQ-004 Port clk, input, 1: the clock; all state SHALL change on its rising edge.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port wr_en, input, 1: producer write request.
REQ-007 Port wr_data, input, WIDTH: producer write data.
REQ-008 Port full, output, 1: no free entry.
REQ-009 Port read, input, 1: consumer pop request from the transmit sequencer.
REQ-010 Port empty, output, 1: no stored entry.
REQ-011 Port data, output, WIDTH: registered popped entry, feeding the UART transmitter data input.
REQ-012 Port overflow, output, 1: one-cycle pulse on a rejected write.
REQ-013 Port underflow, output, 1: one-cycle pulse on a rejected read.

Function
REQ-014 A write SHALL be accepted when wr_en=1 and full=0; wr_data SHALL be stored at wr_ptr, and wr_ptr SHALL increment.
REQ-015 A read SHALL be accepted when read=1 and empty=0; data SHALL load mem[rd_ptr] at that edge, and rd_ptr SHALL increment.
REQ-016 Read latency SHALL be exactly one cycle: data is valid from the cycle after the read and is held until the next accepted read.
REQ-017 Pointers SHALL be DEPTH_LOG2+1 bits and wrap modulo 2*DEPTH; the memory index SHALL be the low DEPTH_LOG2 bits.
REQ-018 empty SHALL be 1 iff the pointers are equal; full SHALL be 1 iff the index bits are equal and the MSBs differ.
REQ-019 full and empty SHALL be decoded from registered pointers only, with no combinational path from any input.
REQ-020 A write while full SHALL be dropped, leave all state unchanged, and pulse overflow for one cycle.
REQ-021 A read while empty SHALL be ignored, leave data unchanged, and pulse underflow for one cycle.
REQ-022 Simultaneous read and write while empty: the write SHALL be accepted, the read SHALL be rejected (underflow pulse), and empty SHALL fall the next cycle.
REQ-023 Simultaneous read and write while full: both SHALL be accepted, and full SHALL remain 1.
REQ-024 Simultaneous accepted read and write otherwise: occupancy SHALL be unchanged.
REQ-025 Occupancy SHALL equal the number of accepted writes minus accepted reads, and SHALL never exceed DEPTH.

Reset
REQ-026 Asserting rst SHALL immediately clear both pointers and set empty=1, full=0, data=0, overflow=0 and underflow=0.
REQ-027 Reset during any operation SHALL discard all stored entries; memory contents need not be cleared.
REQ-028 The first edge after rst deasserts SHALL accept a write normally.

Configuration
REQ-029 When macro UART_TX_FIFO_LEVEL_EN is defined, the block SHALL add output level [DEPTH_LOG2:0], equal to wr_ptr-rst-free rd_ptr difference (wr_ptr minus rd_ptr, modulo 2*DEPTH) and registered-pointer derived.
REQ-030 With UART_TX_FIFO_LEVEL_EN defined, the block SHALL also add output almost_full, which is 1 when level is at least DEPTH-2; almost_full SHALL reset to 0.
REQ-031 Without UART_TX_FIFO_LEVEL_EN, the level and almost_full ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 Shared package uart_pkg SHALL hold UART_DATA_W=8 (the WIDTH default) and UART_TX_FIFO_DEPTH_LOG2=4.
REQ-033 Storage SHALL be a sub-module uart_tx_fifo_mem: a synchronous-write, asynchronous-read array with one write port and one read port, no reset.
REQ-034 Pointer, flag and output-register logic SHALL reside in uart_tx_fifo.

Verification
REQ-035 Reset, then write 0x41 -> empty falls next cycle; pulse read -> data=0x41 one cycle later, and empty=1.
REQ-036 Write 16 bytes 0x00..0x0F -> full=1 after the 16th; 17th write 0xFF -> overflow pulses once, and a drain yields 0x00..0x0F in order.
REQ-037 Read while empty -> underflow pulses once and data holds its last value.
REQ-038 When full, read and write 0xAA in the same cycle -> full stays 1, and 0xAA is output 16th after drain; when empty, read and write in the same cycle -> underflow pulses and level=1.
REQ-039 Assert rst mid-burst with 5 entries -> empty=1 and data=0 immediately; pointers wrap correctly over 40 write/read cycles.
REQ-040 With UART_TX_FIFO_LEVEL_EN defined, write 14 entries -> level=14 and almost_full=1; at 13 entries, almost_full=0.
